// File: rtl/dtc_feature_binarizer.sv
// dtc_feature_binarizer: thresholds 11 raw samples into a registered 11-bit feature vector.
// Define DTC_BIN_FRAME_CHECK_EN to check in_last framing and drive a sticky frame_err.
module dtc_feature_binarizer #(
  parameter int DATA_W = 8,
  parameter int N_FEAT = 11,
  parameter logic [N_FEAT*DATA_W-1:0] THRESH = {11{8'h80}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_FEAT-1:0] out_feat,
  output logic              frame_err
);
  localparam int IW = $clog2(N_FEAT);
  localparam logic [IW-1:0] LAST = IW'(N_FEAT - 1);
  logic [IW-1:0] idx_q, idx_d;
  logic [N_FEAT-2:0] acc_q, acc_d;
  logic [N_FEAT-1:0] out_feat_q, out_feat_d, cmp;
  logic out_valid_q, out_valid_d, frame_err_q, frame_err_d;
  logic fire, last_beat, bit_in, ferr, load;
  for (genvar g = 0; g < N_FEAT; g++) begin : g_cmp
    assign cmp[g] = in_data > THRESH[g*DATA_W +: DATA_W];
  end
  assign last_beat = idx_q == LAST;
  assign in_ready  = !last_beat || !out_valid_q || out_ready;
  assign fire      = in_valid && in_ready;
  assign bit_in    = cmp[idx_q];
`ifdef DTC_BIN_FRAME_CHECK_EN
  assign ferr = fire && (in_last != last_beat);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign ferr = 1'b0;
`endif
  assign load = fire && last_beat && !ferr;
  always_comb begin
    acc_d = acc_q;
    if (fire && !last_beat) acc_d[idx_q] = bit_in;
    idx_d       = (ferr || (fire && last_beat)) ? '0 : fire ? idx_q + 1'b1 : idx_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_feat_d  = load ? {bit_in, acc_q} : out_feat_q;
    frame_err_d = frame_err_q || ferr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_feat_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_feat_q  <= out_feat_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_feat  = out_feat_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_dtc_feature_binarizer.sv
// tb_dtc_feature_binarizer: scoreboard bench; expected vectors are queued as beats are accepted.
module tb_dtc_feature_binarizer;
  logic clk = 0;
  logic rst_n, in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
  logic [7:0] in_data;
  logic [10:0] out_feat;
  int chk_cnt = 0, pass_cnt = 0, pulses = 0, stalls = 0;
  int cyc = 0, prev_cyc = 0, last_gap = 0, m_idx = 0;
  logic [10:0] m_bits = '0;
  logic [10:0] exp_q[$];
  logic exp_ferr = 0;

  dtc_feature_binarizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_feat(out_feat), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
`ifdef DTC_BIN_FRAME_CHECK_EN
    if (l != (m_idx == 10)) begin
      m_idx = 0;
      exp_ferr = 1;
      return;
    end
`endif
    m_bits[m_idx] = d > 8'h80;
    if (m_idx == 10) begin
      exp_q.push_back(m_bits);
      m_idx = 0;
    end else m_idx++;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int w = 0;
    in_valid = 1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++; stalls++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    else model_accept(d, l);
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input logic [87:0] v);
    for (int i = 0; i < 11; i++) send_beat(v[i*8 +: 8], i == 10);
  endtask

  task automatic idle();
    in_valid = 0; in_last = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pulses++;
      last_gap = cyc - prev_cyc;
      prev_cyc = cyc;
      if (exp_q.size() == 0) check("spurious_vec", 1, 0);
      else check("vec", out_feat, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [87:0] v;
    int base;
    rst_n = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_feat", out_feat, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk); #1 rst_n = 1;

    send_vec({11{8'h81}});
    idle();
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_feat", out_feat, 11'h7FF);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_pulse", out_valid, 0);

    for (int i = 0; i < 11; i++) v[i*8 +: 8] = (i % 2) ? 8'hFF : 8'h80;
    @(posedge clk); #1;
    send_vec(v);
    idle();
    @(negedge clk);
    check("t2_equal_gives_0", out_feat, 11'h2AA);
    @(posedge clk); #1;

    out_ready = 0;
    for (int i = 0; i < 11; i++) v[i*8 +: 8] = 8'(i * 25);
    send_vec(v);
    for (int i = 0; i < 10; i++) send_beat(8'(255 - i * 25), 0);
    in_valid = 1; in_data = 8'd5; in_last = 1;
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_valid", out_valid, 1);
    check("stall_feat", out_feat, 11'h7C0);
    @(posedge clk); #1;
    @(negedge clk);
    check("hold_feat", out_feat, 11'h7C0);
    check("hold_in_ready", in_ready, 0);
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    model_accept(8'd5, 1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    check("reload_valid", out_valid, 1);
    check("reload_feat", out_feat, 11'h03F);
    @(posedge clk); #1;
    @(negedge clk);
    check("reload_drained", out_valid, 0);
    @(posedge clk); #1;

    base = pulses; stalls = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 11; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
      send_vec(v);
    end
    idle();
    repeat (3) @(posedge clk); #1;
    check("stream_pulses", pulses - base, 3);
    check("stream_gap", last_gap, 11);
    check("stream_stalls", stalls, 0);

`ifdef DTC_BIN_FRAME_CHECK_EN
    base = pulses;
    for (int i = 0; i < 5; i++) send_beat(8'hFF, 0);
    send_beat(8'hFF, 1);
    idle();
    @(negedge clk);
    check("ferr_set", frame_err, 1);
    @(posedge clk); #1;
    send_vec({11{8'h81}});
    idle();
    repeat (3) @(posedge clk); #1;
    check("ferr_one_vec", pulses - base, 1);
    check("ferr_sticky", frame_err, 1);
`endif
    check("frame_err_model", frame_err, exp_ferr);

    out_ready = 0;
    send_vec({11{8'hFF}});
    for (int i = 0; i < 7; i++) send_beat(8'h10, 0);
    idle();
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_feat", out_feat, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_ferr", frame_err, 0);
    exp_q.delete(); m_idx = 0; exp_ferr = 0;
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    for (int i = 0; i < 11; i++) v[i*8 +: 8] = (i < 5) ? 8'hFF : 8'h00;
    send_vec(v);
    idle();
    @(negedge clk);
    check("post_rst_feat", out_feat, 11'h01F);
    repeat (3) @(posedge clk); #1;
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
